// File: rtl/threshold_sequencer_pkg.sv
// Shared definitions for the adaptive-threshold sequencer.
// The stage modules decode global_state using the same encodings.
package threshold_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CYC_W   = 32;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_BOX    = 3'd1,
    ST_THRESH = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd7
  } state_e;

  // Identifies which requester owns a read that is still in flight.
  typedef struct packed {
    logic th;
    logic dbg;
  } rd_tag_t;

  function automatic logic is_busy(input state_e s);
    return (s == ST_BOX) || (s == ST_THRESH);
  endfunction

endpackage

// File: rtl/threshold_sequencer_if.sv
// Middle-RAM read port shared by the threshold stage and the debug reader.
interface threshold_sequencer_if
  import threshold_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_BITS  = 8,
  parameter int unsigned HEIGHT_BITS = 8
);
  logic                   iThRdReq;
  logic [WIDTH_BITS-1:0]  iThRdCol;
  logic [HEIGHT_BITS-1:0] iThRdRow;
  logic                   oThRdGrant;
  logic                   oThRdValid;
  logic                   iDbgRdReq;
  logic [WIDTH_BITS-1:0]  iDbgRdCol;
  logic [HEIGHT_BITS-1:0] iDbgRdRow;
  logic                   oDbgRdGrant;
  logic                   oDbgRdValid;
  logic [WIDTH_BITS-1:0]  oRdCol;
  logic [HEIGHT_BITS-1:0] oRdRow;
  logic [DATA_W-1:0]      iRdData;
  logic [DATA_W-1:0]      oRdData;

  modport slave (
    input  iThRdReq, iThRdCol, iThRdRow, iDbgRdReq, iDbgRdCol, iDbgRdRow, iRdData,
    output oThRdGrant, oThRdValid, oDbgRdGrant, oDbgRdValid, oRdCol, oRdRow, oRdData
  );

  modport master (
    output iThRdReq, iThRdCol, iThRdRow, iDbgRdReq, iDbgRdCol, iDbgRdRow, iRdData,
    input  oThRdGrant, oThRdValid, oDbgRdGrant, oDbgRdValid, oRdCol, oRdRow, oRdData
  );

endinterface

// File: rtl/middle_rd_arbiter.sv
// Fixed-priority arbiter for the middle-RAM read port with a tag pipeline
// that steers returned data to the requester that issued the read.
module middle_rd_arbiter
  import threshold_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_BITS  = 8,
  parameter int unsigned HEIGHT_BITS = 8,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   th_eligible,
  threshold_sequencer_if.slave   rd
);

  logic                   th_gnt_c;
  logic                   dbg_gnt_c;
  logic [WIDTH_BITS-1:0]  col_d, col_q;
  logic [HEIGHT_BITS-1:0] row_d, row_q;
  rd_tag_t                tag_d [RD_LATENCY];
  rd_tag_t                tag_q [RD_LATENCY];
  logic                   th_valid_d, th_valid_q;
  logic                   dbg_valid_d, dbg_valid_q;
  logic [DATA_W-1:0]      data_d, data_q;

  always_comb begin
    th_gnt_c  = th_eligible & rd.iThRdReq;
    dbg_gnt_c = rd.iDbgRdReq & ~th_gnt_c;

    // Without a grant the RAM keeps seeing the last address driven.
    col_d = col_q;
    row_d = row_q;
    if (th_gnt_c) begin
      col_d = rd.iThRdCol;
      row_d = rd.iThRdRow;
    end else if (dbg_gnt_c) begin
      col_d = rd.iDbgRdCol;
      row_d = rd.iDbgRdRow;
    end

    tag_d[0].th  = th_gnt_c;
    tag_d[0].dbg = dbg_gnt_c;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    th_valid_d  = tag_q[RD_LATENCY-1].th;
    dbg_valid_d = tag_q[RD_LATENCY-1].dbg;
    data_d      = rd.iRdData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      th_valid_q  <= 1'b0;
      dbg_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      tag_q       <= tag_d;
      th_valid_q  <= th_valid_d;
      dbg_valid_q <= dbg_valid_d;
      data_q      <= data_d;
    end
  end

  assign rd.oThRdGrant  = th_gnt_c;
  assign rd.oDbgRdGrant = dbg_gnt_c;
  assign rd.oRdCol      = col_d;
  assign rd.oRdRow      = row_d;
  assign rd.oThRdValid  = th_valid_q;
  assign rd.oDbgRdValid = dbg_valid_q;
  assign rd.oRdData     = data_q;

endmodule

// File: rtl/threshold_sequencer.sv
// Sequences the box-filter and threshold stages with a per-stage watchdog,
// measures busy time, and owns the middle-RAM read arbiter.
module threshold_sequencer
  import threshold_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_BITS     = 8,
  parameter int unsigned HEIGHT_BITS    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 262144,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iStart,
  output logic [STATE_W-1:0]  global_state,
  input  logic                iBoxFinished,
  input  logic                iThFinished,
  output logic                oBusy,
  output logic                oError,
  output logic [CYC_W-1:0]    oCycles,
  threshold_sequencer_if.slave rd
);

  localparam logic [CYC_W-1:0] WDOG_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

  state_e           state_d, state_q;
  logic [CYC_W-1:0] wdog_d, wdog_q;
  logic [CYC_W-1:0] cycles_d, cycles_q;
  logic             busy_d, busy_q;
  logic             error_d, error_q;
  logic             timeout_c;

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    cycles_d  = cycles_q;
    timeout_c = (wdog_q >= WDOG_LAST);

    // A stage's finished input outranks a watchdog expiry in the same cycle.
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (iStart) state_d = ST_BOX;
      ST_BOX: begin
        if (iBoxFinished)   state_d = ST_THRESH;
        else if (timeout_c) state_d = ST_ERROR;
      end
      ST_THRESH: begin
        if (iThFinished)    state_d = ST_DONE;
        else if (timeout_c) state_d = ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q)  wdog_d = '0;
    else if (is_busy(state_q)) wdog_d = wdog_q + CYC_W'(1);

    if ((state_d == ST_BOX) && (state_q != ST_BOX)) begin
      cycles_d = '0;
    end else if (is_busy(state_q) && (cycles_q != '1)) begin
      cycles_d = cycles_q + CYC_W'(1);
    end

    busy_d  = is_busy(state_d);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wdog_q   <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdog_q   <= wdog_d;
      cycles_q <= cycles_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  assign global_state = state_q;
  assign oBusy        = busy_q;
  assign oError       = error_q;
  assign oCycles      = cycles_q;

  middle_rd_arbiter #(
    .WIDTH_BITS (WIDTH_BITS),
    .HEIGHT_BITS(HEIGHT_BITS),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_arb (
    .clock      (clock),
    .reset      (reset),
    .th_eligible(state_q == ST_THRESH),
    .rd         (rd)
  );

endmodule

// File: tb/tb_threshold_sequencer.sv
// Directed bench: stage sequencing, watchdog timeout, read arbitration and reset flush.
module tb_threshold_sequencer;

  logic        clk;
  logic        reset;
  logic        iStart, iBoxFinished, iThFinished;
  logic [2:0]  global_state;
  logic        oBusy, oError;
  logic [31:0] oCycles;
  logic        iStart2;
  logic [2:0]  global_state2;
  logic        oBusy2, oError2;
  logic [31:0] oCycles2;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  threshold_sequencer_if #(.WIDTH_BITS(8), .HEIGHT_BITS(8)) rd_if ();
  threshold_sequencer_if #(.WIDTH_BITS(8), .HEIGHT_BITS(8)) rd_if2 ();

  threshold_sequencer #(
    .WIDTH_BITS(8), .HEIGHT_BITS(8), .TIMEOUT_CYCLES(262144), .RD_LATENCY(1)
  ) dut (
    .clock(clk), .reset(reset), .iStart(iStart), .global_state(global_state),
    .iBoxFinished(iBoxFinished), .iThFinished(iThFinished), .oBusy(oBusy),
    .oError(oError), .oCycles(oCycles), .rd(rd_if)
  );

  threshold_sequencer #(
    .WIDTH_BITS(8), .HEIGHT_BITS(8), .TIMEOUT_CYCLES(16), .RD_LATENCY(1)
  ) dut_to (
    .clock(clk), .reset(reset), .iStart(iStart2), .global_state(global_state2),
    .iBoxFinished(1'b0), .iThFinished(1'b0), .oBusy(oBusy2),
    .oError(oError2), .oCycles(oCycles2), .rd(rd_if2)
  );

  function automatic logic [7:0] ram_byte(input logic [7:0] c, input logic [7:0] r);
    return 8'(c * 7 + r * 13 + 8'h21);
  endfunction

  // Middle RAM model with one cycle of read latency.
  always @(posedge clk) rd_if.iRdData <= ram_byte(rd_if.oRdCol, rd_if.oRdRow);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    iStart = 1'b0; iBoxFinished = 1'b0; iThFinished = 1'b0; iStart2 = 1'b0;
    rd_if.iThRdReq = 1'b0; rd_if.iThRdCol = '0; rd_if.iThRdRow = '0;
    rd_if.iDbgRdReq = 1'b0; rd_if.iDbgRdCol = '0; rd_if.iDbgRdRow = '0;
    rd_if2.iThRdReq = 1'b0; rd_if2.iThRdCol = '0; rd_if2.iThRdRow = '0;
    rd_if2.iDbgRdReq = 1'b0; rd_if2.iDbgRdCol = '0; rd_if2.iDbgRdRow = '0;
    rd_if2.iRdData = '0;
    tick(2);
    check("rst_state", 32'(global_state), 0);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_error", 32'(oError), 0);
    check("rst_cycles", oCycles, 0);
    check("rst_thvalid", 32'(rd_if.oThRdValid), 0);
    check("rst_dbgvalid", 32'(rd_if.oDbgRdValid), 0);
    check("rst_rddata", 32'(rd_if.oRdData), 0);
    reset = 1'b0;
    tick(1);

    // Normal run: BOX for 100 cycles, THRESH for 50.
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    check("box_entry", 32'(global_state), 1);
    check("box_busy", 32'(oBusy), 1);
    rd_if.iThRdReq = 1'b1; rd_if.iThRdCol = 8'd3; rd_if.iThRdRow = 8'd5;
    #1;
    check("box_th_nogrant", 32'(rd_if.oThRdGrant), 0);
    tick(2);
    check("box_th_novalid_a", 32'(rd_if.oThRdValid), 0);
    tick(1);
    check("box_th_novalid_b", 32'(rd_if.oThRdValid), 0);
    rd_if.iThRdReq = 1'b0;
    tick(96);
    check("box_hold", 32'(global_state), 1);
    iBoxFinished = 1'b1;
    tick(1);
    check("thresh_entry", 32'(global_state), 2);
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    check("start_ignored", 32'(global_state), 2);

    // Both requesters in THRESH: threshold wins.
    rd_if.iThRdReq = 1'b1; rd_if.iThRdCol = 8'd3; rd_if.iThRdRow = 8'd5;
    rd_if.iDbgRdReq = 1'b1; rd_if.iDbgRdCol = 8'd9; rd_if.iDbgRdRow = 8'd9;
    #1;
    check("arb_th_grant", 32'(rd_if.oThRdGrant), 1);
    check("arb_dbg_nogrant", 32'(rd_if.oDbgRdGrant), 0);
    check("arb_col", 32'(rd_if.oRdCol), 3);
    check("arb_row", 32'(rd_if.oRdRow), 5);
    tick(1);
    rd_if.iThRdReq = 1'b0; rd_if.iDbgRdReq = 1'b0;
    check("th_valid_early", 32'(rd_if.oThRdValid), 0);
    tick(1);
    check("th_valid", 32'(rd_if.oThRdValid), 1);
    check("th_data", 32'(rd_if.oRdData), 32'h77);
    check("th_no_dbgvalid", 32'(rd_if.oDbgRdValid), 0);
    tick(1);
    check("th_valid_once", 32'(rd_if.oThRdValid), 0);
    check("addr_hold_col", 32'(rd_if.oRdCol), 3);
    check("addr_hold_row", 32'(rd_if.oRdRow), 5);
    tick(45);
    check("stale_box_finish", 32'(global_state), 2);
    iThFinished = 1'b1;
    tick(1);
    iThFinished = 1'b0; iBoxFinished = 1'b0;
    check("done_entry", 32'(global_state), 3);
    check("done_busy", 32'(oBusy), 0);
    check("done_cycles", oCycles, 150);
    tick(5);
    check("done_cycles_frozen", oCycles, 150);
    check("done_hold", 32'(global_state), 3);

    // Back-to-back debug reads in DONE.
    rd_if.iDbgRdReq = 1'b1; rd_if.iDbgRdCol = 8'd0; rd_if.iDbgRdRow = 8'd0;
    #1;
    check("dbg_grant", 32'(rd_if.oDbgRdGrant), 1);
    check("dbg_no_thgrant", 32'(rd_if.oThRdGrant), 0);
    tick(1);
    rd_if.iDbgRdCol = 8'd1;
    tick(1);
    rd_if.iDbgRdCol = 8'd2;
    check("dbg_valid0", 32'(rd_if.oDbgRdValid), 1);
    check("dbg_data0", 32'(rd_if.oRdData), 32'h21);
    tick(1);
    rd_if.iDbgRdReq = 1'b0;
    check("dbg_valid1", 32'(rd_if.oDbgRdValid), 1);
    check("dbg_data1", 32'(rd_if.oRdData), 32'h28);
    tick(1);
    check("dbg_valid2", 32'(rd_if.oDbgRdValid), 1);
    check("dbg_data2", 32'(rd_if.oRdData), 32'h2F);
    check("dbg_no_thvalid", 32'(rd_if.oThRdValid), 0);
    tick(1);
    check("dbg_valid_end", 32'(rd_if.oDbgRdValid), 0);

    // Watchdog on the short-timeout instance.
    iStart2 = 1'b1;
    tick(1);
    iStart2 = 1'b0;
    check("to_box_entry", 32'(global_state2), 1);
    tick(15);
    check("to_box_last", 32'(global_state2), 1);
    check("to_no_error_yet", 32'(oError2), 0);
    tick(1);
    check("to_error_state", 32'(global_state2), 7);
    check("to_error_flag", 32'(oError2), 1);
    check("to_error_busy", 32'(oBusy2), 0);
    check("to_error_cycles", oCycles2, 16);
    iStart2 = 1'b1;
    tick(1);
    iStart2 = 1'b0;
    check("to_restart_state", 32'(global_state2), 1);
    check("to_restart_error", 32'(oError2), 0);
    check("to_restart_cycles", oCycles2, 0);

    // Finish on the first BOX cycle, then reset with a read in flight.
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    iBoxFinished = 1'b1;
    tick(1);
    iBoxFinished = 1'b0;
    check("first_cycle_finish", 32'(global_state), 2);
    rd_if.iThRdReq = 1'b1; rd_if.iThRdCol = 8'd4; rd_if.iThRdRow = 8'd2;
    #1;
    check("flush_grant", 32'(rd_if.oThRdGrant), 1);
    tick(1);
    rd_if.iThRdReq = 1'b0;
    reset = 1'b1;
    #1;
    check("async_rst_state", 32'(global_state), 0);
    check("async_rst_cycles", oCycles, 0);
    check("async_rst_busy", 32'(oBusy), 0);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flush_no_valid", 32'(rd_if.oThRdValid), 0);
      tick(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
